// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, default sizing, parity.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        PUSH
    } rx_state_t;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int WORD_SIZE_DEF    = 8;

    // Zero-extension does not change the XOR, so any word up to 32 bits fits.
    function automatic logic calcParity(input logic [31:0] dataWord, input logic oddSel);
        return (^dataWord) ^ oddSel;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; output lags input by 2 cycles.
// Flops reset to RST_VAL so an idle-high line does not look like an edge after reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// Oversampling UART receiver that pushes good bytes into the RX FIFO, write strobe
// CLKS_PER_BIT/2 + CLKS_PER_BIT*(WORD_SIZE+1+PARITY_EN) + 1 cycles after the start edge; FIFO not ready drops the byte and flags overrun.
module uart_rx_fifo_writer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 writeClk_in,
    input  logic                 rstN,
    input  logic                 rx_in,
    input  logic                 fifoInReady_in,
    input  logic                 clrErr_in,
    output logic                 writeEn_out,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 busy_flag,
    output logic                 frameErr_flag,
    output logic                 parityErr_flag,
    output logic                 overrun_flag
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_SIZE - 1);
    localparam logic             ODD_SEL   = (PARITY_ODD != 0);

    rx_state_t            state;
    rx_state_t            stateNext;
    logic                 rxs;
    logic                 rxPrev;
    logic [CNT_W-1:0]     bitCnt;
    logic [CNT_W-1:0]     cntNext;
    logic [IDX_W-1:0]     bitIdx;
    logic [WORD_SIZE-1:0] shiftReg;
    logic [WORD_SIZE-1:0] dataHold;
    logic                 badByte;
    logic                 sampleTick;
    logic                 shiftEn;
    logic                 frameErrSet;
    logic                 parityErrSet;
    logic                 overrunSet;
    logic                 pushOk;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rxSync (
        .clk (writeClk_in),
        .rstN(rstN),
        .d   (rx_in),
        .q   (rxs)
    );

    always_ff @(posedge writeClk_in) begin
        if (!rstN) begin
            state          <= IDLE;
            rxPrev         <= 1'b1;
            bitCnt         <= '0;
            bitIdx         <= '0;
            shiftReg       <= '0;
            dataHold       <= '0;
            badByte        <= 1'b0;
            frameErr_flag  <= 1'b0;
            parityErr_flag <= 1'b0;
            overrun_flag   <= 1'b0;
        end else begin
            state  <= stateNext;
            rxPrev <= rxs;
            bitCnt <= cntNext;

            if (state == START) begin
                bitIdx <= '0;
            end else if (shiftEn) begin
                bitIdx <= bitIdx + 1'b1;
            end

            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            if (shiftEn) begin
                shiftReg <= {rxs, shiftReg[WORD_SIZE-1:1]};
            end

            if (state == IDLE) begin
                badByte <= 1'b0;
            end else if (parityErrSet) begin
                badByte <= 1'b1;
            end

            if (pushOk) begin
                dataHold <= shiftReg;
            end

            // A new error in the same cycle as a clear keeps the flag set.
            frameErr_flag  <= frameErrSet  | (frameErr_flag  & ~clrErr_in);
            parityErr_flag <= parityErrSet | (parityErr_flag & ~clrErr_in);
            overrun_flag   <= overrunSet   | (overrun_flag   & ~clrErr_in);
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = bitCnt;
        sampleTick   = (bitCnt == '0);
        shiftEn      = 1'b0;
        frameErrSet  = 1'b0;
        parityErrSet = 1'b0;
        overrunSet   = 1'b0;
        pushOk       = 1'b0;

        case (state)
            IDLE: begin
                if (rxPrev && !rxs) begin
                    stateNext = START;
                    cntNext   = HALF_LOAD;
                end
            end
            START: begin
                if (!sampleTick) begin
                    cntNext = bitCnt - 1'b1;
                end else if (rxs) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = DATA;
                    cntNext   = FULL_LOAD;
                end
            end
            DATA: begin
                if (!sampleTick) begin
                    cntNext = bitCnt - 1'b1;
                end else begin
                    shiftEn = 1'b1;
                    cntNext = FULL_LOAD;
                    if (bitIdx == LAST_IDX) begin
                        stateNext = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (!sampleTick) begin
                    cntNext = bitCnt - 1'b1;
                end else begin
                    cntNext   = FULL_LOAD;
                    stateNext = STOP;
                    if (rxs != calcParity(32'(shiftReg), ODD_SEL)) begin
                        parityErrSet = 1'b1;
                    end
                end
            end
            STOP: begin
                if (!sampleTick) begin
                    cntNext = bitCnt - 1'b1;
                end else if (!rxs) begin
                    frameErrSet = 1'b1;
                    stateNext   = IDLE;
                end else begin
                    stateNext = badByte ? IDLE : PUSH;
                end
            end
            PUSH: begin
                stateNext = IDLE;
                if (fifoInReady_in) begin
                    pushOk = 1'b1;
                end else begin
                    overrunSet = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // The byte is shown only on the strobe cycle so a dropped byte never disturbs data_out.
    assign writeEn_out = pushOk;
    assign data_out    = pushOk ? shiftReg : dataHold;
    assign busy_flag   = (state != IDLE);

endmodule
